// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, fetches words from imem over req/ack and hands them to
// decode over valid/ready, with redirect handling, wrong-path squash and misalignment fault.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_1000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        misaligned
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD,
      S_FAULT
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              squash_q, squash_d;
   logic              req_d;
   logic [XLEN-1:0]   addr_d;
   logic              valid_d;
   logic [XLEN-1:0]   out_d;
   logic [XLEN-1:0]   ipc_d;
   logic              mis_d;

   logic              ack_c;
   logic              redir_ok_c;
   logic              redir_bad_c;
   logic [XLEN-1:0]   pc_inc_c;

   // An ack only counts while a request is actually outstanding.
   assign ack_c       = imem_req & imem_ack;
   assign redir_ok_c  = redirect_valid & (redirect_pc[1:0] == 2'b00);
   assign redir_bad_c = redirect_valid & (redirect_pc[1:0] != 2'b00);
   assign pc_inc_c    = pc_q + XLEN'(4);

   // Next-state and next-output logic; every registered output is computed here.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      squash_d = squash_q;
      req_d    = imem_req;
      addr_d   = imem_addr;
      valid_d  = instr_valid;
      out_d    = instr_out;
      ipc_d    = instr_pc;
      mis_d    = misaligned;

      if (state_q != S_FAULT && redir_bad_c) begin
         // Misaligned target: abandon any outstanding request and halt until reset.
         state_d  = S_FAULT;
         squash_d = 1'b0;
         req_d    = 1'b0;
         valid_d  = 1'b0;
         out_d    = NOP_INSTR;
         mis_d    = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_REQ;
               req_d   = 1'b1;
               if (redir_ok_c) begin
                  pc_d   = redirect_pc;
                  addr_d = redirect_pc;
               end else begin
                  addr_d = pc_q;
               end
            end

            S_REQ: begin
               if (redir_ok_c) begin
                  pc_d    = redirect_pc;
                  valid_d = 1'b0;
                  out_d   = NOP_INSTR;
                  if (ack_c) begin
                     // Response arriving now is dropped directly; restart at the target.
                     squash_d = 1'b0;
                     addr_d   = redirect_pc;
                  end else begin
                     // Handshake must complete on the old address; drop its response.
                     squash_d = 1'b1;
                  end
               end else if (ack_c) begin
                  if (squash_q) begin
                     squash_d = 1'b0;
                     addr_d   = pc_q;
                  end else begin
                     state_d = S_HOLD;
                     req_d   = 1'b0;
                     valid_d = 1'b1;
                     out_d   = imem_rdata;
                     ipc_d   = pc_q;
                  end
               end
            end

            S_HOLD: begin
               if (redir_ok_c) begin
                  state_d = S_REQ;
                  pc_d    = redirect_pc;
                  req_d   = 1'b1;
                  addr_d  = redirect_pc;
                  valid_d = 1'b0;
                  out_d   = NOP_INSTR;
               end else if (instr_ready) begin
                  state_d = S_REQ;
                  pc_d    = pc_inc_c;
                  req_d   = 1'b1;
                  addr_d  = pc_inc_c;
                  valid_d = 1'b0;
                  out_d   = NOP_INSTR;
               end
            end

            S_FAULT: begin
               req_d   = 1'b0;
               valid_d = 1'b0;
               mis_d   = 1'b1;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         squash_q    <= 1'b0;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         instr_valid <= 1'b0;
         instr_out   <= NOP_INSTR;
         instr_pc    <= RESET_PC;
         misaligned  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         squash_q    <= squash_d;
         imem_req    <= req_d;
         imem_addr   <= addr_d;
         instr_valid <= valid_d;
         instr_out   <= out_d;
         instr_pc    <= ipc_d;
         misaligned  <= mis_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: per-cycle vector table, directed multi-cycle sequences, and a
// randomized run checked against a program-order model of the fetch stream.
module tb_instruction_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        misaligned;

   int n_pass = 0;
   int n_total = 0;

   instruction_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .misaligned     (misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        ack;
      logic [31:0] rdata;
      logic        ready;
      logic        rv;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_out;
      logic [31:0] e_pc;
      logic        e_mis;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input logic rst, input logic ack, input logic [31:0] rdata,
                               input logic ready, input logic rv, input logic [31:0] rpc,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_out,
                               input logic [31:0] e_pc, input logic e_mis);
      vec_t v;
      v.rst = rst; v.ack = ack; v.rdata = rdata; v.ready = ready; v.rv = rv; v.rpc = rpc;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_out = e_out;
      v.e_pc = e_pc; v.e_mis = e_mis;
      return v;
   endfunction

   // Contents the bench's instruction memory returns for an address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int          wait_cnt;
      int          delivered;
      logic [31:0] exp_pc;
      logic        prev_req;
      logic        prev_ack;
      logic [31:0] prev_addr;

      // rst ack rdata ready rv rpc | req addr valid out pc mis
      vecs[0]  = mk(1, 0, 0,            0, 0, 0,            0, 32'h1000, 0, NOP,          32'h1000, 0);
      vecs[1]  = mk(0, 0, 0,            1, 0, 0,            1, 32'h1000, 0, NOP,          0,        0);
      vecs[2]  = mk(0, 0, 0,            1, 0, 0,            1, 32'h1000, 0, NOP,          0,        0);
      vecs[3]  = mk(0, 1, 32'hA000_0000, 1, 0, 0,           0, 0,        1, 32'hA000_0000, 32'h1000, 0);
      vecs[4]  = mk(0, 0, 0,            1, 0, 0,            1, 32'h1004, 0, NOP,          0,        0);
      vecs[5]  = mk(0, 0, 0,            1, 0, 0,            1, 32'h1004, 0, NOP,          0,        0);
      vecs[6]  = mk(0, 1, 32'hA000_0001, 1, 0, 0,           0, 0,        1, 32'hA000_0001, 32'h1004, 0);
      vecs[7]  = mk(0, 0, 0,            1, 0, 0,            1, 32'h1008, 0, NOP,          0,        0);
      vecs[8]  = mk(0, 0, 0,            1, 0, 0,            1, 32'h1008, 0, NOP,          0,        0);
      vecs[9]  = mk(0, 1, 32'hA000_0002, 1, 0, 0,           0, 0,        1, 32'hA000_0002, 32'h1008, 0);
      vecs[10] = mk(0, 0, 0,            1, 1, 32'h3000,     1, 32'h3000, 0, NOP,          0,        0);
      vecs[11] = mk(0, 1, 32'hA000_0003, 0, 0, 0,           0, 0,        1, 32'hA000_0003, 32'h3000, 0);
      vecs[12] = mk(0, 0, 0,            0, 1, 32'h2002,     0, 0,        0, NOP,          0,        1);
      vecs[13] = mk(0, 1, 32'hBAD0_BAD0, 1, 1, 32'h4000,    0, 0,        0, NOP,          0,        1);
      vecs[14] = mk(0, 0, 0,            0, 0, 0,            0, 0,        0, NOP,          0,        1);
      vecs[15] = mk(1, 0, 0,            0, 0, 0,            0, 32'h1000, 0, NOP,          32'h1000, 0);
      vecs[16] = mk(0, 0, 0,            0, 0, 0,            1, 32'h1000, 0, NOP,          0,        0);
      vecs[17] = mk(0, 1, 32'hA000_0004, 0, 0, 0,           0, 0,        1, 32'hA000_0004, 32'h1000, 0);

      for (int i = 0; i < 18; i++) begin
         reset          = vecs[i].rst;
         imem_ack       = vecs[i].ack;
         imem_rdata     = vecs[i].rdata;
         instr_ready    = vecs[i].ready;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         step();
         chk1($sformatf("v%0d_req", i), imem_req, vecs[i].e_req);
         chk1($sformatf("v%0d_valid", i), instr_valid, vecs[i].e_valid);
         chk1($sformatf("v%0d_mis", i), misaligned, vecs[i].e_mis);
         chk($sformatf("v%0d_out", i), instr_out, vecs[i].e_out);
         if (vecs[i].e_req || vecs[i].rst) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
         if (vecs[i].e_valid || vecs[i].rst) chk($sformatf("v%0d_pc", i), instr_pc, vecs[i].e_pc);
      end
      imem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;

      // Backpressure: held word stays put with no fetch, then next fetch is pc+4.
      for (int i = 0; i < 5; i++) begin
         step();
         chk1("bp_valid", instr_valid, 1'b1);
         chk("bp_out", instr_out, 32'hA000_0004);
         chk("bp_pc", instr_pc, 32'h1000);
         chk1("bp_req", imem_req, 1'b0);
      end
      instr_ready = 1'b1;
      step();
      chk1("bp_next_req", imem_req, 1'b1);
      chk("bp_next_addr", imem_addr, 32'h1004);
      chk1("bp_next_valid", instr_valid, 1'b0);

      // Redirect while the 0x1004 fetch is pending; its late response must be dropped.
      instr_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h2000;
      step();
      redirect_valid = 1'b0;
      chk("sq_hold_addr0", imem_addr, 32'h1004);
      chk1("sq_hold_req0", imem_req, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("sq_hold_addr", imem_addr, 32'h1004);
         chk1("sq_valid", instr_valid, 1'b0);
      end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      chk1("sq_drop_valid", instr_valid, 1'b0);
      chk("sq_drop_out", instr_out, NOP);
      chk1("sq_new_req", imem_req, 1'b1);
      chk("sq_new_addr", imem_addr, 32'h2000);
      imem_ack = 1'b0;
      step();
      chk("sq_new_addr2", imem_addr, 32'h2000);
      imem_ack = 1'b1; imem_rdata = 32'h5555_0000;
      step();
      imem_ack = 1'b0;
      chk1("sq_word_valid", instr_valid, 1'b1);
      chk("sq_word_pc", instr_pc, 32'h2000);
      chk("sq_word_out", instr_out, 32'h5555_0000);

      // PC wrap at the top of the address space.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      chk1("wrap_valid0", instr_valid, 1'b0);
      imem_ack = 1'b1; imem_rdata = 32'h6666_0000;
      step();
      imem_ack = 1'b0;
      chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      chk1("wrap_req", imem_req, 1'b1);
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      imem_ack = 1'b1; imem_rdata = 32'h7777_0000;
      step();
      imem_ack = 1'b0;
      chk("wrap_word_pc", instr_pc, 32'h0000_0000);
      chk("wrap_word_out", instr_out, 32'h7777_0000);

      // Randomized run: every accepted word must be the next word in program order.
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_pc = 32'h1000;
      wait_cnt = -1;
      delivered = 0;
      prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         chk1("inv_req_valid", imem_req & instr_valid, 1'b0);
         if (!instr_valid) chk("inv_idle_nop", instr_out, NOP);
         if (prev_req && !prev_ack && imem_req) chk("inv_addr_stable", imem_addr, prev_addr);

         imem_ack = 1'b0;
         imem_rdata = $urandom;
         if (imem_req) begin
            if (wait_cnt < 0) wait_cnt = int'($urandom_range(0, 3));
            if (wait_cnt == 0) begin
               imem_ack = 1'b1;
               imem_rdata = mem_word(imem_addr);
               wait_cnt = -1;
            end else begin
               wait_cnt--;
            end
         end else if ($urandom_range(0, 7) == 0) begin
            imem_ack = 1'b1;
         end
         instr_ready = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc = redirect_valid ? ($urandom & 32'hFFFF_FFFC) : $urandom;

         if (redirect_valid) begin
            exp_pc = redirect_pc;
         end else if (instr_valid && instr_ready) begin
            chk("rnd_pc", instr_pc, exp_pc);
            chk("rnd_word", instr_out, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
         step();
      end
      redirect_valid = 1'b0; imem_ack = 1'b0;
      chk1("rnd_progress", delivered >= 150, 1'b1);
      chk1("rnd_no_fault", misaligned, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
